// File: rtl/mult_share_ctrl_if.sv
// Request and result handshake bundle for the shared multiplier.
// master drives requests and consumes results; slave is the controller.
interface mult_share_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*WIDTH-1:0]    out_product;
    logic [IDW-1:0]        out_id;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_product, out_id
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_product, out_id
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin shared shift-add signed multiplier.
// One partial product per cycle; result tagged with requester ID.
module mult_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    mult_share_ctrl_if.slave   bus,
    output logic               busy
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, state_n;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant;
    logic             found;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             take;
    logic             give;

    logic [PW-1:0]    a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_n;
    logic [PW-1:0]    addend;
    logic [SW-1:0]    step;
    logic [PW-1:0]    prod_q;
    logic [IDW-1:0]   oid_q;
    logic             ovld_q;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[ptr + IDW'(i)]) begin
                grant = ptr + IDW'(i);
                found = 1'b1;
            end
        end
    end

    assign a_sel = bus.req_a[int'(grant) * WIDTH +: WIDTH];
    assign b_sel = bus.req_b[int'(grant) * WIDTH +: WIDTH];
    assign take  = (state == IDLE) && found && !rst;
    assign give  = ovld_q && bus.out_ready;

    always_comb begin
        bus.req_ready = '0;
        if (take)
            bus.req_ready[grant] = 1'b1;
    end

    // The b sign bit carries negative weight, hence the subtract.
    assign addend = a_q << step;
    always_comb begin
        acc_n = acc;
        if (b_q[step])
            acc_n = (step == LAST) ? acc - addend : acc + addend;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (take) state_n = MUL;
            MUL:  if (step == LAST) state_n = DONE;
            DONE: if (give) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            acc    <= '0;
            step   <= '0;
            prod_q <= '0;
            oid_q  <= '0;
            ovld_q <= 1'b0;
        end else begin
            if (take) begin
                a_q  <= {{WIDTH{a_sel[WIDTH-1]}}, a_sel};
                b_q  <= b_sel;
                id_q <= grant;
                ptr  <= grant + IDW'(1);
                acc  <= '0;
                step <= '0;
            end
            if (state == MUL) begin
                acc  <= acc_n;
                step <= step + SW'(1);
                if (step == LAST) begin
                    prod_q <= acc_n;
                    oid_q  <= id_q;
                    ovld_q <= 1'b1;
                end
            end
            if (give)
                ovld_q <= 1'b0;
        end
    end

    assign bus.out_valid   = ovld_q;
    assign bus.out_product = prod_q;
    assign bus.out_id      = oid_q;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl.
// Accepted requests push a model product; result handshakes pop and compare.
module tb_mult_share_ctrl;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0]  id;
        logic [2*W-1:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    mult_share_ctrl_if #(.WIDTH(W), .NREQ(N), .IDW(IW)) bus ();

    mult_share_ctrl #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    exp_t sb[$];
    exp_t e_q;
    int   acc_id[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [7:0]  ca [4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [7:0]  cb [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
    logic [15:0] cp [4] = '{16'h4000, 16'hC080, 16'h0000, 16'h0001};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] model(logic [7:0] a, logic [7:0] b);
        logic signed [15:0] x;
        x = $signed(a) * $signed(b);
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb.push_back('{id: IW'(i),
                        p: model(bus.req_a[i*W +: W], bus.req_b[i*W +: W])});
                    acc_id.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e_q = sb.pop_front();
                    check("sb_id", 32'(bus.out_id), 32'(e_q.id));
                    check("sb_prod", 32'(bus.out_product), 32'(e_q.p));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(int i, logic [7:0] a, logic [7:0] b);
        int k;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i] = 1'b1;
        #1;
        k = 0;
        while (!bus.req_ready[i] && k < 64) begin
            tick();
            k++;
        end
        if (!bus.req_ready[i])
            check("req_timeout", 32'd0, 32'd1);
        tick();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            tick();
            k++;
        end
        if (!bus.out_valid)
            check("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_acc(int base);
        int k;
        k = 0;
        while (acc_id.size() <= base && k < 40) begin
            tick();
            k++;
        end
        if (acc_id.size() <= base)
            check("acc_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int c_set;
        logic [15:0] p0;
        logic [1:0]  id0;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.out_ready = 1'b1;
        tick();
        bus.req_valid = '1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_prod", 32'(bus.out_product), 32'd0);
        check("rst_out_id", 32'(bus.out_id), 32'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        // single request, fixed latency
        request(1, 8'hFD, 8'h05);
        check("t1_rdy_pulse", 32'(bus.req_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (7) tick();
        check("t1_early", 32'(bus.out_valid), 32'd0);
        tick();
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_prod", 32'(bus.out_product), 32'h0000FFF1);
        check("t1_id", 32'(bus.out_id), 32'd1);
        tick();

        // corner products
        for (int k = 0; k < 4; k++) begin
            request(k, ca[k], cb[k]);
            wait_out();
            check("corner_prod", 32'(bus.out_product), 32'(cp[k]));
            tick();
        end

        // round-robin with all requesters held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = 8'(10 + 7 * i);
            bus.req_b[i*W +: W] = 8'(-(3 + 2 * i));
        end
        base = acc_id.size();
        bus.req_valid = '1;
        for (int k = 0; k < 80 && acc_id.size() < base + 5; k++)
            tick();
        bus.req_valid = '0;
        check("rr_count", 32'(acc_id.size() - base), 32'd5);
        if (acc_id.size() >= base + 5) begin
            for (int k = 0; k < 5; k++)
                check("rr_id", 32'(acc_id[base + k]), 32'(k % 4));
            for (int k = 1; k < 5; k++)
                check("rr_gap", 32'(acc_cyc[base + k] - acc_cyc[base + k - 1]), 32'd10);
        end
        wait_out();
        tick();

        // backpressure
        bus.out_ready = 1'b0;
        request(2, 8'd11, 8'hF9);
        bus.req_a[3*W +: W] = 8'h21;
        bus.req_b[3*W +: W] = 8'h83;
        bus.req_valid[3] = 1'b1;
        wait_out();
        p0 = bus.out_product;
        id0 = bus.out_id;
        check("bp_prod", 32'(p0), 32'h0000FFB3);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_prod_hold", 32'(bus.out_product), 32'(p0));
            check("bp_id_hold", 32'(bus.out_id), 32'(id0));
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        base = acc_id.size();
        bus.out_ready = 1'b1;
        c_set = cyc;
        wait_acc(base);
        bus.req_valid[3] = 1'b0;
        if (acc_id.size() > base) begin
            check("bp_next_cyc", 32'(acc_cyc[base]), 32'(c_set + 1));
            check("bp_next_id", 32'(acc_id[base]), 32'd3);
        end
        wait_out();
        tick();

        // reset mid-operation
        request(1, 8'h25, 8'h13);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        bus.req_valid = 4'b0101;
        #1;
        check("mid_ptr", 32'(bus.req_ready), 32'd1);
        bus.req_valid = '0;
        request(2, 8'h9C, 8'h07);
        wait_out();
        check("mid_prod", 32'(bus.out_product), 32'h0000FD44);
        check("mid_id", 32'(bus.out_id), 32'd2);
        tick();

        // withdrawn request is skipped
        request(1, 8'h03, 8'h04);
        tick();
        bus.req_a[3*W +: W] = 8'hF0;
        bus.req_b[3*W +: W] = 8'h05;
        bus.req_valid[0] = 1'b1;
        bus.req_valid[3] = 1'b1;
        tick();
        bus.req_valid[0] = 1'b0;
        base = acc_id.size();
        wait_out();
        tick();
        wait_acc(base);
        bus.req_valid[3] = 1'b0;
        if (acc_id.size() > base)
            check("wd_next_id", 32'(acc_id[base]), 32'd3);
        wait_out();
        tick();
        repeat (3) tick();
        check("wd_no_more", 32'(acc_id.size() - base), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one iterative shift-add signed multiplier between NREQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Sequences the datapath one partial product per cycle.
- Returns each product, tagged with the requester ID, through a valid/ready result port.
- Sits between multiple producer blocks (e.g. filter taps, address generators) and a single multiply resource.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- NREQ, 4, number of requesters; must be 4 in this revision.
- IDW, 2, requester ID width; equals log2(NREQ).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept strobe.
- req_a  input  NREQ*WIDTH  multiplicands; requester i at bits [i*WIDTH +: WIDTH]; two's complement.
- req_b  input  NREQ*WIDTH  multipliers; same packing as req_a.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_product  output  2*WIDTH  signed product.
- out_id  output  IDW  requester index that owns out_product.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; round-robin pointer resets to 0.
  - out_valid, out_product, out_id, busy all go to 0.
  - req_ready is 0 for the whole cycle rst is high.
  - Reset mid-operation aborts the operation; no result is ever emitted for it.
- States: IDLE, MUL, DONE.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from ptr upward with wrap.
  - req_ready[grant]=1, combinational from req_valid and state; all other req_ready bits are 0.
  - Handshake (valid & ready) latches req_a[grant], req_b[grant] and grant.
  - On handshake: ptr <= grant+1 mod NREQ, accumulator cleared, step counter cleared, next state MUL.
  - No requests: stay in IDLE, ptr unchanged.
- MUL: WIDTH cycles, step k = 0..WIDTH-1.
  - A = a sign-extended to 2*WIDTH.
  - If b[k]=1: acc <= acc + (A<<k) for k<WIDTH-1, and acc <= acc - (A<<k) for k=WIDTH-1 (negative weight of the b sign bit).
  - All arithmetic is modulo 2^(2*WIDTH).
  - After step WIDTH-1: out_product <= final acc, out_id <= latched ID, out_valid <= 1, next state DONE.
- DONE:
  - out_valid, out_product and out_id hold stable until out_valid & out_ready.
  - On handshake: out_valid <= 0, next state IDLE.
  - No new request is accepted in DONE.
- Latency: request handshake at edge T gives out_valid=1 after edge T+WIDTH. Earliest next accept is the cycle after the result handshake.
- Throughput: one product per WIDTH+2 cycles when out_ready is held high.
- Requester inputs:
  - A requester may drop req_valid before it is granted; it is then simply skipped.
  - Operand changes after the handshake do not affect the in-flight product.
- Fairness: a continuously requesting requester waits at most NREQ-1 other operations.
- busy = (state != IDLE).

Test Plan:
- Single request, id1, a=-3 (8'hFD), b=5:
  - req_ready[1] pulses for 1 cycle.
  - 8 cycles later out_valid=1, out_product=16'hFFF1, out_id=1.
- Corner products, each on its own request, out_ready=1:
  - a=-128, b=-128 -> 16'h4000.
  - a=127, b=-128 -> 16'hC080.
  - a=0, b=-1 -> 16'h0000.
  - a=-1, b=-1 -> 16'h0001.
- Round-robin: all four req_valid held high with distinct operands for 5 operations.
  - out_id sequence is 0,1,2,3,0; each product is correct.
  - Accept cycles are spaced exactly 10 cycles apart.
- Backpressure: out_ready held low for 5 cycles after out_valid rises.
  - out_valid, out_product and out_id stay stable.
  - req_ready stays 0 throughout.
  - Next accept occurs on the cycle after out_ready=1.
- Reset mid-op: rst=1 for 1 cycle at MUL step 3.
  - Next cycle: busy=0, out_valid=0, ptr=0.
  - A subsequent request from id2 completes normally; no stale result appears.
- Withdrawn request: req_valid[0] pulses for 1 cycle while the block is in MUL, and req_valid[3] is held.
  - id0 is never granted; id3 is granted next.
